keyboard_ctl: RTL
=================

KEYBOARD_CTL -- requirements
Module: keyboard_ctl

Interface
REQ-001 Parameter ALT_KEYS_EN, default 1, enables A/D keys as aliases for left/right arrows when 1.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx_data  input  8  PS/2 scan-code byte from the receiver.
REQ-005 rx_valid  input  1  single-cycle strobe; rx_data SHALL be sampled only when rx_valid=1.
REQ-006 m_left  output  1  registered level: move-left request to the player controller.
REQ-007 m_right  output  1  registered level: move-right request to the player controller.

Function
REQ-008 Decoding SHALL use PS/2 set-2 codes:
- Left arrow = E0 6B.
- Right arrow = E0 74.
- A = 1C and D = 23, both non-extended.
- Break prefix = F0.
- Extended prefix = E0.
REQ-009 The parser FSM SHALL have states IDLE, EXT, BRK and EXT_BRK, and SHALL change state only on cycles with rx_valid=1.
REQ-010 IDLE transitions:
- E0 -> EXT.
- F0 -> BRK.
- Any other byte is a make code and SHALL be decoded, then the FSM returns to IDLE.
REQ-011 EXT transitions:
- F0 -> EXT_BRK.
- E0 -> stay in EXT.
- Any other byte is an extended make code and SHALL be decoded, then -> IDLE.
REQ-012 BRK transitions:
- F0 -> stay in BRK.
- E0 -> EXT (malformed sequence, restart).
- Any other byte is a break code and SHALL be decoded, then -> IDLE.
REQ-013 EXT_BRK transitions:
- Any byte other than E0/F0 is an extended break code and SHALL be decoded, then -> IDLE.
- E0 -> EXT.
- F0 -> stay in EXT_BRK.
REQ-014 The block SHALL keep four held flags: l_arr, r_arr, a_key, d_key.
- Make code: sets the matching flag.
- Break code: clears the matching flag.
- Unrecognised codes SHALL leave all flags unchanged.
REQ-015 Extension matching:
- 6B/74 SHALL match only in extended context.
- 1C/23 SHALL match only in non-extended context.
- With ALT_KEYS_EN=0, a_key and d_key SHALL stay 0.
REQ-016 left_held = l_arr|a_key; right_held = r_arr|d_key.
REQ-017 A last-direction register SHALL record which direction most recently went from not-held to held.
REQ-018 m_left and m_right SHALL never both be 1:
- If only one side is held, that side's output is 1.
- If both are held, the last-direction side wins.
- If neither is held, both outputs are 0.
REQ-019 When the winning side is released while the other side remains held, the other side's output SHALL assert on the next cycle.
REQ-020 Outputs SHALL reflect a completed code on the clock edge following the edge that samples the final byte, i.e. 1-cycle latency.
REQ-021 Typematic repeats of a make code SHALL change neither the held flags nor last-direction.
REQ-022 Consecutive rx_valid strobes on back-to-back cycles SHALL each be processed with no byte lost.
REQ-023 The block SHALL contain no timeout; an incomplete prefix SHALL persist until the next byte arrives.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL go to FSM=IDLE with all held flags=0, last-direction=right, and m_left=m_right=0, regardless of any code in progress.
REQ-025 rst SHALL take priority over rx_valid on the same edge, and that byte SHALL be discarded.
REQ-026 After reset, a sequence interrupted mid-code SHALL NOT resume; the next byte SHALL be parsed from IDLE.

Verification
REQ-027 Extended press/release: E0, 74 -> m_right=1 one cycle after the 74 strobe; then E0, F0, 74 -> m_right=0 one cycle after the final strobe; m_left=0 throughout.
REQ-028 Overlap: press D (23), then left arrow (E0 6B) -> m_left=1 and m_right=0; release left (E0 F0 6B) -> m_right=1 on the next cycle.
REQ-029 Context checks:
- 6B without E0 -> no change.
- 1C after E0 -> no change.
- With ALT_KEYS_EN=0, 1C -> m_left stays 0.
REQ-030 Reset mid-code: send E0, F0, assert rst for one cycle, then send 6B -> treated as non-extended make, outputs stay 0, and a previously held right is cleared by the reset.
REQ-031 Back-to-back bytes and repeats:
- E0 and 6B on consecutive cycles -> m_left=1.
- Ten repeats of E0 6B -> m_left stays 1.
- One E0 F0 6B -> m_left=0.
REQ-032 Random byte stream of at least 10k bytes checked against a reference model -> m_left&m_right never 1, and both outputs match the model every cycle.

Source files
------------

// File: rtl/keyboard_ctl.sv
// PS/2 set-2 scan-code parser producing mutually exclusive move-left/move-right levels.
// Whichever side was pressed last wins while both sides are held.
module keyboard_ctl #(
  parameter bit ALT_KEYS_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       m_left,
  output logic       m_right
);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_LARR  = 8'h6B;
  localparam logic [7:0] CODE_RARR  = 8'h74;
  localparam logic [7:0] CODE_A     = 8'h1C;
  localparam logic [7:0] CODE_D     = 8'h23;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_code;
  logic   w_ext;
  logic   w_brk;

  logic   r_l_arr, r_r_arr, r_a_key, r_d_key;
  logic   w_l_arr_nxt, w_r_arr_nxt, w_a_key_nxt, w_d_key_nxt;
  logic   r_last_right;
  logic   w_last_right_nxt;
  logic   w_left_held, w_right_held;
  logic   w_left_held_nxt, w_right_held_nxt;
  logic   r_m_left, r_m_right;

  // Parser: prefixes only move the FSM, any other byte completes a code.
  always_comb begin
    w_state_nxt = r_state;
    w_code      = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    if (rx_valid) begin
      unique case (r_state)
        IDLE: begin
          if (rx_data == CODE_EXT)      w_state_nxt = EXT;
          else if (rx_data == CODE_BRK) w_state_nxt = BRK;
          else begin
            w_code      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        EXT: begin
          if (rx_data == CODE_BRK)      w_state_nxt = EXT_BRK;
          else if (rx_data == CODE_EXT) w_state_nxt = EXT;
          else begin
            w_code      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        BRK: begin
          if (rx_data == CODE_BRK)      w_state_nxt = BRK;
          else if (rx_data == CODE_EXT) w_state_nxt = EXT;
          else begin
            w_code      = 1'b1;
            w_brk       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        EXT_BRK: begin
          if (rx_data == CODE_EXT)      w_state_nxt = EXT;
          else if (rx_data == CODE_BRK) w_state_nxt = EXT_BRK;
          else begin
            w_code      = 1'b1;
            w_ext       = 1'b1;
            w_brk       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Held-flag update; a repeated make rewrites an already-set flag, so nothing rises.
  always_comb begin
    w_l_arr_nxt = r_l_arr;
    w_r_arr_nxt = r_r_arr;
    w_a_key_nxt = r_a_key;
    w_d_key_nxt = r_d_key;
    if (w_code) begin
      if (w_ext) begin
        if (rx_data == CODE_LARR) w_l_arr_nxt = ~w_brk;
        if (rx_data == CODE_RARR) w_r_arr_nxt = ~w_brk;
      end else if (ALT_KEYS_EN) begin
        if (rx_data == CODE_A) w_a_key_nxt = ~w_brk;
        if (rx_data == CODE_D) w_d_key_nxt = ~w_brk;
      end
    end
  end

  assign w_left_held      = r_l_arr | r_a_key;
  assign w_right_held     = r_r_arr | r_d_key;
  assign w_left_held_nxt  = w_l_arr_nxt | w_a_key_nxt;
  assign w_right_held_nxt = w_r_arr_nxt | w_d_key_nxt;

  always_comb begin
    w_last_right_nxt = r_last_right;
    if (w_left_held_nxt && !w_left_held)   w_last_right_nxt = 1'b0;
    if (w_right_held_nxt && !w_right_held) w_last_right_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_l_arr      <= 1'b0;
      r_r_arr      <= 1'b0;
      r_a_key      <= 1'b0;
      r_d_key      <= 1'b0;
      r_last_right <= 1'b1;
      r_m_left     <= 1'b0;
      r_m_right    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_l_arr      <= w_l_arr_nxt;
      r_r_arr      <= w_r_arr_nxt;
      r_a_key      <= w_a_key_nxt;
      r_d_key      <= w_d_key_nxt;
      r_last_right <= w_last_right_nxt;
      // Arbitration runs off the registered flags, giving one cycle from final byte to output.
      r_m_left     <= w_left_held  & (~w_right_held | ~r_last_right);
      r_m_right    <= w_right_held & (~w_left_held  |  r_last_right);
    end
  end

  assign m_left  = r_m_left;
  assign m_right = r_m_right;

endmodule
